// File: rtl/matmul_job_sequencer.sv
// Job controller for the 8x8 fp16 matrix multiplier: loads A and B, runs compute
// and drains C, then sweeps the C BRAMs and flags each valid output word.
module matmul_job_sequencer #(
  parameter int AWIDTH    = 16,
  parameter int DATA_W    = 2048,
  parameter int NUM_WORDS = 8,
  parameter int WR_ALIGN  = 2,
  parameter int RD_LAT    = 4,
  parameter int C_DRAIN   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_start,
  output logic              job_busy,
  output logic              job_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [15:0]       compute_cycles,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [DATA_W-1:0] data_pi,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              start_mat_mul,
  input  logic              done_mat_mul
);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, WR_FLUSH, COMPUTE, DRAIN, READ, RD_FLUSH, FIN
  } state_e;

  localparam int CNT_W = 16;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [15:0]         cyc_q;
  logic [AWIDTH-1:0]   addr_q;
  logic                in_ready_q, en_wr_q, en_rd_q, start_q, we_c_q, busy_q, done_q;
  logic [WR_ALIGN:0]   wr_a_q, wr_b_q;
  logic [DATA_W-1:0]   wr_data_q [WR_ALIGN+1];
  logic [RD_LAT-1:0]   rd_vld_q, rd_last_q;
  logic                accept, last_word;

  assign accept    = in_valid & in_ready_q;
  assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (job_start) state_d = LOAD_A;
      LOAD_A:   if (accept && last_word) state_d = LOAD_B;
      LOAD_B:   if (accept && last_word) state_d = WR_FLUSH;
      WR_FLUSH: if (cnt_q == CNT_W'(WR_ALIGN)) state_d = COMPUTE;
      COMPUTE:  if (done_mat_mul) state_d = DRAIN;
      DRAIN:    if (cnt_q == CNT_W'(C_DRAIN - 1)) state_d = READ;
      READ:     if (last_word) state_d = RD_FLUSH;
      RD_FLUSH: if (rd_last_q[RD_LAT-1]) state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; outputs are decoded from state_d so they are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cyc_q      <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      en_wr_q    <= 1'b0;
      en_rd_q    <= 1'b0;
      start_q    <= 1'b0;
      we_c_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_a_q     <= '0;
      wr_b_q     <= '0;
      rd_vld_q   <= '0;
      rd_last_q  <= '0;
      // NOTE: the write data delay line is reset too, so an aborted job leaves
      // nothing in flight and data_pi reads back as zero after reset.
      for (int i = 0; i <= WR_ALIGN; i++) wr_data_q[i] <= '0;
    end else begin
      state_q <= state_d;

      // One shared counter: words in LOAD_*/READ, cycles in WR_FLUSH/DRAIN.
      if (state_d != state_q)
        cnt_q <= '0;
      else if (accept || state_q inside {WR_FLUSH, DRAIN, READ})
        cnt_q <= cnt_q + 1'b1;

      if (state_q != COMPUTE && state_d == COMPUTE)
        cyc_q <= '0;
      else if (state_q == COMPUTE && !done_mat_mul && cyc_q != 16'hFFFF)
        cyc_q <= cyc_q + 1'b1;

      if (accept)
        addr_q <= AWIDTH'(cnt_q);
      else if (state_d == READ)
        addr_q <= (state_q == READ) ? AWIDTH'(cnt_q + 1'b1) : '0;

      in_ready_q <= state_d inside {LOAD_A, LOAD_B};
      en_wr_q    <= state_d inside {LOAD_A, LOAD_B, WR_FLUSH};
      en_rd_q    <= state_d inside {READ, RD_FLUSH};
      start_q    <= (state_d == COMPUTE);
      we_c_q     <= state_d inside {COMPUTE, DRAIN};
      busy_q     <= (state_d != IDLE) && (state_d != FIN);
      done_q     <= (state_d == FIN);

      // Write strobes and data trail addr_pi by WR_ALIGN cycles.
      wr_a_q[0]    <= accept && (state_q == LOAD_A);
      wr_b_q[0]    <= accept && (state_q == LOAD_B);
      wr_data_q[0] <= accept ? in_data : '0;
      for (int i = 1; i <= WR_ALIGN; i++) begin
        wr_a_q[i]    <= wr_a_q[i-1];
        wr_b_q[i]    <= wr_b_q[i-1];
        wr_data_q[i] <= wr_data_q[i-1];
      end

      // A read address is live while state_q is READ; its data returns RD_LAT later.
      rd_vld_q[0]  <= (state_q == READ);
      rd_last_q[0] <= (state_q == READ) && last_word;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_last_q[i] <= rd_last_q[i-1];
      end
    end
  end

  assign job_busy                = busy_q;
  assign job_done                = done_q;
  assign in_ready                = in_ready_q;
  assign out_valid               = rd_vld_q[RD_LAT-1];
  assign out_last                = rd_last_q[RD_LAT-1];
  assign compute_cycles          = cyc_q;
  assign enable_writing_to_mem   = en_wr_q;
  assign enable_reading_from_mem = en_rd_q;
  assign addr_pi                 = addr_q;
  assign data_pi                 = wr_data_q[WR_ALIGN];
  assign we_a                    = wr_a_q[WR_ALIGN];
  assign we_b                    = wr_b_q[WR_ALIGN];
  assign we_c                    = we_c_q;
  assign start_mat_mul           = start_q;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed bench for matmul_job_sequencer: cycle-exact load table, compute/read
// sequences, a gapped job, and reset abort followed by a clean job.
module tb_matmul_job_sequencer;

  localparam int AWIDTH = 16;
  localparam int DATA_W = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic              job_start, job_busy, job_done;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_last;
  logic [15:0]       compute_cycles;
  logic              enable_writing_to_mem, enable_reading_from_mem;
  logic [AWIDTH-1:0] addr_pi;
  logic [DATA_W-1:0] data_pi;
  logic              we_a, we_b, we_c, start_mat_mul, done_mat_mul;

  matmul_job_sequencer dut (
    .clk(clk), .reset(reset),
    .job_start(job_start), .job_busy(job_busy), .job_done(job_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_last(out_last), .compute_cycles(compute_cycles),
    .enable_writing_to_mem(enable_writing_to_mem),
    .enable_reading_from_mem(enable_reading_from_mem),
    .addr_pi(addr_pi), .data_pi(data_pi),
    .we_a(we_a), .we_b(we_b), .we_c(we_c),
    .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [15:0] in_data;
    logic        exp_ready;
    logic [15:0] exp_addr;
    logic        exp_we_a;
    logic        exp_we_b;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [19];
  int   n_pass = 0;
  int   n_total = 0;
  int   p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full job driven by the bench; done_mat_mul is raised done_m cycles into COMPUTE.
  task automatic run_job(input bit gapped, input int done_m, input bit poke);
    int          idx = 0, seen = 0, n_a = 0, n_b = 0, n_ov = 0, n_last = 0;
    bit          drove, finished = 0;
    logic [15:0] h1, h2;
    h1 = addr_pi; h2 = addr_pi;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (we_a) begin n_a++; check("pair_a", data_pi[15:0], h2); end
      if (we_b) begin n_b++; check("pair_b", data_pi[15:0], 32'(h2) + 8); end
      if (we_a && we_b) check("we_overlap", 1, 0);
      if (out_valid) n_ov++;
      if (out_last) begin n_last++; check("last_has_valid", out_valid, 1); end
      if (job_done) begin finished = 1; check("busy_at_done", job_busy, 0); end
      if (start_mat_mul) seen++;
      done_mat_mul = (start_mat_mul && seen == done_m + 1) || (poke && cyc == 3);
      job_start    = poke && (cyc == 5);
      drove        = in_ready && idx < 16 && (!gapped || cyc[0]);
      in_valid     = drove;
      in_data      = {128{16'(idx)}};
      h2 = h1; h1 = addr_pi;
      tick();
      if (drove) idx++;
    end
    in_valid = 1'b0; done_mat_mul = 1'b0; job_start = 1'b0;
    check("job_finished", finished, 1);
    check("job_done_pulse_width", job_done, 0);
    check("n_we_a", n_a, 8);
    check("n_we_b", n_b, 8);
    check("n_out_valid", n_ov, 8);
    check("n_out_last", n_last, 1);
    check("compute_cycles", compute_cycles, done_m);
    repeat (3) tick();
    check("idle_busy_after", job_busy, 0);
    check("idle_ready_after", in_ready, 0);
  endtask

  initial begin
    reset = 1'b1; job_start = 1'b0; in_valid = 1'b0; in_data = '0; done_mat_mul = 1'b0;

    for (int i = 0; i < 19; i++) begin
      p = i + 1;
      tbl[i].in_valid  = (i < 16);
      tbl[i].in_data   = (i < 16) ? 16'(i) : 16'd0;
      tbl[i].exp_ready = (p <= 16);
      tbl[i].exp_addr  = (p < 2) ? 16'd0 : (p <= 17) ? 16'((p - 2) % 8) : 16'd7;
      tbl[i].exp_we_a  = (p >= 4 && p <= 11);
      tbl[i].exp_we_b  = (p >= 12 && p <= 19);
      tbl[i].exp_data  = (p >= 4) ? 16'(p - 4) : 16'd0;
    end

    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_busy", job_busy, 0);
    check("rst_done", job_done, 0);
    check("rst_ready", in_ready, 0);
    check("rst_outs", {out_valid, out_last, we_a, we_b, we_c, start_mat_mul}, 0);
    check("rst_enables", {enable_writing_to_mem, enable_reading_from_mem}, 0);
    check("rst_addr", addr_pi, 0);
    check("rst_cycles", compute_cycles, 0);
    check("rst_data", |data_pi, 0);

    // Job 1: back-to-back load, cycle-exact.
    job_start = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      job_start = 1'b0;
      check("ld_busy", job_busy, 1);
      check("ld_en_wr", enable_writing_to_mem, 1);
      check("ld_ready", in_ready, tbl[i].exp_ready);
      check("ld_addr", addr_pi, tbl[i].exp_addr);
      check("ld_we_a", we_a, tbl[i].exp_we_a);
      check("ld_we_b", we_b, tbl[i].exp_we_b);
      check("ld_data_lo", data_pi[15:0], tbl[i].exp_data);
      check("ld_data_hi", data_pi[DATA_W-1 -: 16], tbl[i].exp_data);
      in_valid = tbl[i].in_valid;
      in_data  = {128{tbl[i].in_data}};
    end

    tick();
    check("cmp_start", start_mat_mul, 1);
    check("cmp_we_c", we_c, 1);
    check("cmp_en_wr_drop", enable_writing_to_mem, 0);
    check("cmp_cycles_zero", compute_cycles, 0);
    repeat (37) tick();
    check("cmp_cycles_37", compute_cycles, 37);
    check("cmp_start_held", start_mat_mul, 1);
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    check("drn_start_fall", start_mat_mul, 0);
    check("drn_we_c0", we_c, 1);
    check("drn_cycles", compute_cycles, 37);
    tick();
    check("drn_we_c1", we_c, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("rd_we_c", we_c, 0);
      check("rd_en", enable_reading_from_mem, 1);
      check("rd_busy", job_busy, 1);
      check("rd_addr", addr_pi, (k <= 7) ? k : 7);
      check("rd_valid", out_valid, (k >= 4) ? 1 : 0);
      check("rd_last", out_last, (k == 11) ? 1 : 0);
    end
    tick();
    check("fin_done", job_done, 1);
    check("fin_busy", job_busy, 0);
    check("fin_valid", out_valid, 0);
    check("fin_en_rd", enable_reading_from_mem, 0);
    tick();
    check("idle_done", job_done, 0);
    check("idle_addr_hold", addr_pi, 7);

    // Job 2: gapped input, stray done and job_start while busy.
    run_job(1'b1, 10, 1'b1);

    // Job 3: reset asserted mid-LOAD_B with writes in flight.
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_data  = {128{16'(i)}};
      tick();
    end
    in_valid = 1'b0;
    check("abort_we_b_pre", we_b, 1);
    check("abort_data_pre", data_pi[15:0], 8);
    reset = 1'b1;
    tick();
    check("abort_we", {we_a, we_b}, 0);
    check("abort_busy", job_busy, 0);
    check("abort_addr", addr_pi, 0);
    tick();
    reset = 1'b0;
    check("abort_we_hold", {we_a, we_b}, 0);
    tick();
    check("abort_we_after", {we_a, we_b}, 0);
    check("abort_ready", in_ready, 0);

    // Job 4: clean job after the abort.
    run_job(1'b0, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
